irq_controller: RTL and testbench

- Collects rising-edge interrupt requests from up to 8 peripherals (mouse, timers, etc.).
- Latches them as pending and applies a bus-writable mask.
- Arbitrates by fixed priority onto the processor's two interrupt lines, BUS_INTERRUPTS_RAISE[1:0], and runs the raise/ack handshake.
- Holds each line busy until the handler writes end-of-interrupt (EOI). Memory-mapped on the shared 8-bit data bus.

---
 rtl/irq_ctrl_pkg.sv | 22 ++
 rtl/irq_line_fsm.sv | 48 ++++
 rtl/irq_controller.sv | 115 +++++++++++
 tb/tb_irq_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register offsets, line FSM encoding and grant helper for irq_controller
package irq_ctrl_pkg;

  localparam logic [7:0] OFS_MASK   = 8'd0;
  localparam logic [7:0] OFS_PEND   = 8'd1;
  localparam logic [7:0] OFS_CAUSE0 = 8'd2;
  localparam logic [7:0] OFS_CAUSE1 = 8'd3;
  localparam logic [7:0] OFS_EOI    = 8'd4;
  localparam logic [7:0] N_REGS     = 8'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAISE = 2'd1,
    BUSY  = 2'd2
  } line_state_e;

  // Isolates the lowest set bit, which is the highest-priority source.
  function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

endpackage

// File: rtl/irq_line_fsm.sv
// rtl/irq_line_fsm.sv - one processor interrupt line: fixed-priority grant, raise/ack, hold until EOI
module irq_line_fsm
  import irq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] candidates,
  input  logic       ack,
  input  logic       eoi,
  output logic       raise,
  output logic       grant_valid,
  output logic [7:0] grant_onehot,
  output logic [7:0] cause
);

  line_state_e state, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cause <= 8'h00;
    end else begin
      state <= state_next;
      if (grant_valid) cause <= grant_onehot;
    end
  end

  always_comb begin
    state_next   = state;
    grant_valid  = 1'b0;
    grant_onehot = 8'h00;
    case (state)
      IDLE: begin
        if (|candidates) begin
          grant_valid  = 1'b1;
          grant_onehot = lowest_onehot(candidates);
          state_next   = RAISE;
        end
      end
      RAISE:   if (ack) state_next = BUSY;
      BUSY:    if (eoi) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign raise = (state == RAISE);

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latched interrupt controller with mask, two prioritised lines and MMIO window
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int         N_SRC     = 8,
  parameter logic [7:0] BASE_ADDR = 8'hD0,
  parameter logic [7:0] LINE1_SRC = 8'hF0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic [7:0]       BUS_ADDR,
  inout  wire  [7:0]       BUS_DATA,
  input  logic             BUS_WE,
  output logic [1:0]       BUS_INTERRUPTS_RAISE,
  input  logic [1:0]       BUS_INTERRUPTS_ACK
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << N_SRC) - 9'd1);

  logic [7:0] irq_wide, prev, rise;
  logic [7:0] mask, pending;
  logic [7:0] ofs, wdata, rd_mux, rd_data_q;
  logic       in_win, wr_mask, wr_pend, wr_eoi, rd, rd_en_q;
  logic [7:0] pend_clr, grant_clr;
  logic [7:0] cand0, cand1, grant0, grant1, cause0, cause1;
  logic       gv0, gv1, raise0, raise1;
  logic [1:0] eoi;

  always_comb begin
    irq_wide            = 8'h00;
    irq_wide[N_SRC-1:0] = IRQ_IN;
  end

  assign rise = irq_wide & ~prev;

  assign ofs     = BUS_ADDR - BASE_ADDR;
  assign in_win  = (ofs < N_REGS);
  assign wdata   = BUS_DATA;
  assign wr_mask = BUS_WE && in_win && (ofs == OFS_MASK);
  assign wr_pend = BUS_WE && in_win && (ofs == OFS_PEND);
  assign wr_eoi  = BUS_WE && in_win && (ofs == OFS_EOI);
  assign rd      = !BUS_WE && in_win;

  assign pend_clr  = wr_pend ? wdata : 8'h00;
  assign eoi       = wr_eoi ? wdata[1:0] : 2'b00;
  assign grant_clr = (gv0 ? grant0 : 8'h00) | (gv1 ? grant1 : 8'h00);

  assign cand0 = pending & mask & ~LINE1_SRC;
  assign cand1 = pending & mask & LINE1_SRC;

  // A fresh edge wins over any clear landing in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev    <= 8'h00;
      pending <= 8'h00;
      mask    <= 8'h00;
    end else begin
      prev    <= irq_wide;
      pending <= ((pending & ~pend_clr & ~grant_clr) | rise) & SRC_MASK;
      if (wr_mask) mask <= wdata & SRC_MASK;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (ofs)
      OFS_MASK:   rd_mux = mask;
      OFS_PEND:   rd_mux = pending;
      OFS_CAUSE0: rd_mux = cause0;
      OFS_CAUSE1: rd_mux = cause1;
      default:    rd_mux = 8'h00;
    endcase
  end

  // The processor samples read data the cycle after it presents the address.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_en_q   <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      rd_en_q   <= rd;
      rd_data_q <= rd ? rd_mux : 8'h00;
    end
  end

  assign BUS_DATA = rd_en_q ? rd_data_q : 8'hzz;

  irq_line_fsm u_line0 (
    .clk          (CLK),
    .rst          (RESET),
    .candidates   (cand0),
    .ack          (BUS_INTERRUPTS_ACK[0]),
    .eoi          (eoi[0]),
    .raise        (raise0),
    .grant_valid  (gv0),
    .grant_onehot (grant0),
    .cause        (cause0)
  );

  irq_line_fsm u_line1 (
    .clk          (CLK),
    .rst          (RESET),
    .candidates   (cand1),
    .ack          (BUS_INTERRUPTS_ACK[1]),
    .eoi          (eoi[1]),
    .raise        (raise1),
    .grant_valid  (gv1),
    .grant_onehot (grant1),
    .cause        (cause1)
  );

  assign BUS_INTERRUPTS_RAISE = {raise1, raise0};

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed self-checking bench for irq_controller
module tb_irq_controller;

  localparam logic [7:0] BASE = 8'hD0;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic [1:0] ack;
  logic [1:0] raise;
  logic       tb_drv;
  logic [7:0] tb_wdata;
  wire  [7:0] bus_data;

  int total = 0;
  int bad   = 0;

  // An undriven bus floats high so a released bus is distinguishable from driven zeros.
  pullup (bus_data);
  assign bus_data = tb_drv ? tb_wdata : 8'hzz;

  irq_controller #(.N_SRC(8), .BASE_ADDR(BASE), .LINE1_SRC(8'hF0)) dut (
    .CLK                  (clk),
    .RESET                (rst),
    .IRQ_IN               (irq_in),
    .BUS_ADDR             (bus_addr),
    .BUS_DATA             (bus_data),
    .BUS_WE               (bus_we),
    .BUS_INTERRUPTS_RAISE (raise),
    .BUS_INTERRUPTS_ACK   (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] o, input logic [7:0] d);
    @(negedge clk);
    bus_addr = BASE + o; bus_we = 1'b1; tb_wdata = d; tb_drv = 1'b1;
    @(negedge clk);
    bus_addr = 8'h00; bus_we = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] o, input logic [7:0] exp);
    @(negedge clk);
    bus_addr = BASE + o; bus_we = 1'b0;
    @(negedge clk);
    check(tag, bus_data, exp);
    bus_addr = 8'h00;
  endtask

  task automatic pulse(input logic [7:0] v);
    @(negedge clk); irq_in = v;
    @(negedge clk); irq_in = 8'h00;
  endtask

  task automatic ack_pulse(input logic [1:0] v);
    @(negedge clk); ack = v;
    @(negedge clk); ack = 2'b00;
  endtask

  task automatic chk_raise(input string tag, input logic [1:0] exp);
    check(tag, {6'b0, raise}, {6'b0, exp});
  endtask

  initial begin
    rst = 1'b1; irq_in = 8'h00; bus_addr = 8'h00; bus_we = 1'b0;
    ack = 2'b00; tb_drv = 1'b0; tb_wdata = 8'h00;
    repeat (2) @(negedge clk);
    chk_raise("raise_in_reset", 2'b00);
    rst = 1'b0;
    step();

    // reset state
    rd_chk("rst_mask", 8'd0, 8'h00);
    rd_chk("rst_pend", 8'd1, 8'h00);
    rd_chk("rst_cause0", 8'd2, 8'h00);
    rd_chk("rst_cause1", 8'd3, 8'h00);
    rd_chk("rst_eoi", 8'd4, 8'h00);
    chk_raise("rst_raise", 2'b00);
    step();
    check("bus_released", bus_data, 8'hFF);

    // single source, ack, held pending until EOI
    wr(8'd0, 8'h04);
    rd_chk("mask_rb", 8'd0, 8'h04);
    pulse(8'h04);
    chk_raise("t2_raise_early", 2'b00);
    step();
    chk_raise("t2_raise", 2'b01);
    rd_chk("t2_cause0", 8'd2, 8'h04);
    ack_pulse(2'b01);
    chk_raise("t2_after_ack", 2'b00);
    pulse(8'h04);
    rd_chk("t2_pend_busy", 8'd1, 8'h04);
    chk_raise("t2_busy_noraise", 2'b00);
    wr(8'd4, 8'h01);
    chk_raise("t2_eoi_gap", 2'b00);
    step();
    chk_raise("t2_reraise", 2'b01);
    rd_chk("t2_pend_after", 8'd1, 8'h00);
    ack_pulse(2'b01);
    wr(8'd4, 8'h01);

    // both lines at once
    wr(8'd0, 8'hFF);
    pulse(8'h22);
    step();
    chk_raise("t3_both", 2'b11);
    rd_chk("t3_cause0", 8'd2, 8'h02);
    rd_chk("t3_cause1", 8'd3, 8'h20);
    ack_pulse(2'b01);
    chk_raise("t3_ack0", 2'b10);
    ack_pulse(2'b10);
    chk_raise("t3_ack1", 2'b00);
    wr(8'd4, 8'h03);
    ack_pulse(2'b11);
    chk_raise("t3_idle_ack", 2'b00);

    // masked pending, then unmask / software clear
    wr(8'd0, 8'h00);
    pulse(8'h08);
    step();
    chk_raise("t4_masked", 2'b00);
    rd_chk("t4_pend", 8'd1, 8'h08);
    wr(8'd0, 8'h08);
    chk_raise("t4_unmask_edge", 2'b00);
    step();
    chk_raise("t4_unmask_raise", 2'b01);
    rd_chk("t4_cause0", 8'd2, 8'h08);
    ack_pulse(2'b01);
    wr(8'd4, 8'h01);
    wr(8'd0, 8'h00);
    pulse(8'h08);
    rd_chk("t4_pend2", 8'd1, 8'h08);
    wr(8'd1, 8'h08);
    rd_chk("t4_pend_clr", 8'd1, 8'h00);
    wr(8'd0, 8'h08);
    step();
    chk_raise("t4_cleared_noraise", 2'b00);

    // priority order on one line
    wr(8'd0, 8'hFF);
    pulse(8'h03);
    step();
    chk_raise("t5_raise_a", 2'b01);
    rd_chk("t5_cause_a", 8'd2, 8'h01);
    rd_chk("t5_pend_a", 8'd1, 8'h02);
    ack_pulse(2'b01);
    wr(8'd4, 8'h01);
    step();
    chk_raise("t5_raise_b", 2'b01);
    rd_chk("t5_cause_b", 8'd2, 8'h02);
    rd_chk("t5_pend_b", 8'd1, 8'h00);
    ack_pulse(2'b01);
    wr(8'd4, 8'h01);

    // reset mid-handshake
    pulse(8'h01);
    step();
    chk_raise("t6_raise", 2'b01);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_raise("t6_async_drop", 2'b00);
    @(negedge clk);
    rst = 1'b0;
    ack_pulse(2'b01);
    chk_raise("t6_post_ack", 2'b00);
    rd_chk("t6_pend", 8'd1, 8'h00);
    rd_chk("t6_mask", 8'd0, 8'h00);
    rd_chk("t6_cause0", 8'd2, 8'h00);
    pulse(8'h01);
    rd_chk("t6_pend_new", 8'd1, 8'h01);
    chk_raise("t6_masked_raise", 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
